// File: rtl/hex_display_driver_if.sv
// ---------------------------------------------------------------------------
// hex_display_driver_if
//   Bundle between the port-3 data source and the 2-digit hex display driver.
//   DIN    [7:0]  value to display (high nibble -> digit 1, low -> digit 0)
//   BLANK         1: all digits dark, scanning continues
//   LZB           1: leading-zero blank on digit 1
//   seg    [6:0]  segments {a,b,c,d,e,f,g}, a = MSB
//   an     [1:0]  digit enables, an[0] = low nibble, an[1] = high nibble
//   frame         one-cycle pulse on each snapshot load
//   master: the source/observer side; slave: the display driver.
// ---------------------------------------------------------------------------
interface hex_display_driver_if;
    logic [7:0] DIN;
    logic       BLANK;
    logic       LZB;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame;

    modport master (
        output DIN, BLANK, LZB,
        input  seg, an, frame
    );

    modport slave (
        input  DIN, BLANK, LZB,
        output seg, an, frame
    );
endinterface

// File: rtl/hex_display_driver.sv
// ---------------------------------------------------------------------------
// hex_display_driver
//   Drives a 2-digit time-multiplexed 7-segment display from an 8-bit value.
//   The value is snapshotted once per frame (at the digit 1 -> 0 transition)
//   so the two digits shown always belong to the same sample.
// Ports:
//   CLK   rising-edge clock
//   CLR   asynchronous active-high reset (outputs dark, timing restarts)
//   bus   hex_display_driver_if.slave: DIN/BLANK/LZB in, seg/an/frame out
// Parameters:
//   PRESCALE    clocks per digit slot (>= 2)
//   ACTIVE_LOW  1: seg/an active-low (common anode), 0: active-high
// ---------------------------------------------------------------------------
module hex_display_driver #(
    parameter int PRESCALE   = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    CLK,
    input  logic                    CLR,
    hex_display_driver_if.slave     bus
);

    localparam int             CNT_W   = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
    localparam logic [6:0]     SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]     AN_OFF  = ACTIVE_LOW ? 2'b11 : 2'b00;

    // Active-high hex decode, {a,b,c,d,e,f,g}
    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] seg_pol(input logic [6:0] s);
        return ACTIVE_LOW ? ~s : s;
    endfunction

    function automatic logic [1:0] an_pol(input logic [1:0] a);
        return ACTIVE_LOW ? ~a : a;
    endfunction

    logic [CNT_W-1:0] cnt;
    logic             dig;
    logic [7:0]       snap;
    logic             blank_q;
    logic [6:0]       seg_q;
    logic [1:0]       an_q;
    logic             frame_q;

    logic             tick;
    logic             frame_start;
    logic             dig_nxt;
    logic [7:0]       snap_nxt;
    logic             upd;
    logic [3:0]       nib;
    logic             lz_blank;
    logic [6:0]       seg_ah;
    logic [1:0]       an_ah;

    // Outputs are computed from the post-edge dig/snap so that the digit
    // driven after a tick (and the freshly loaded snapshot at frame start)
    // appears on the very edge that changes them.
    always_comb begin
        tick        = (cnt == CNT_MAX);
        frame_start = tick & dig;
        dig_nxt     = tick ? ~dig : dig;
        snap_nxt    = frame_start ? bus.DIN : snap;
        // Refresh on ticks, and on every edge while BLANK is or just was high,
        // so blanking and un-blanking act within one edge.
        upd         = tick | bus.BLANK | blank_q;
        nib         = dig_nxt ? snap_nxt[7:4] : snap_nxt[3:0];
        lz_blank    = bus.LZB & dig_nxt & (snap_nxt[7:4] == 4'h0);
        seg_ah      = lz_blank ? 7'h00 : hex_decode(nib);
        an_ah       = bus.BLANK ? 2'b00 : (dig_nxt ? 2'b10 : 2'b01);
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            cnt     <= '0;
            dig     <= 1'b1;
            snap    <= 8'h00;
            blank_q <= 1'b0;
            frame_q <= 1'b0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
        end else begin
            cnt     <= tick ? '0 : cnt + CNT_W'(1);
            dig     <= dig_nxt;
            snap    <= snap_nxt;
            blank_q <= bus.BLANK;
            frame_q <= frame_start;
            if (upd) begin
                seg_q <= seg_pol(seg_ah);
                an_q  <= an_pol(an_ah);
            end
        end
    end

    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.frame = frame_q;

endmodule
